hazard_scoreboard: RTL

Parametrised hazard, forwarding and memory-wait controller for the 5-stage MIPS pipeline. It keeps its own shadow copy of the destination and control state of the instructions in EX, MEM and WB. From that state it produces:
- EX forwarding selects,
- forwarded operands for branch and jr resolution in ID,
- load-use and branch-dependence stalls,
- taken-branch flushes,
- a pipeline freeze while a variable-latency data memory is not ready.

It sits beside the datapath and replaces the scattered forwarding and stall equations of the top level.

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow EX/MEM/WB state driving forwarding, stall, flush and memory-wait control
// for the 5-stage MIPS pipeline.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              IdValid,
  input  logic              IdUsesRs,
  input  logic              IdUsesRt,
  input  logic              IdIsBranch,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic [REG_AW-1:0] IdRs,
  input  logic [REG_AW-1:0] IdRt,
  input  logic [REG_AW-1:0] IdDst,
  input  logic              BranchTaken,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] RfRs,
  input  logic [DATA_W-1:0] RfRt,
  input  logic [DATA_W-1:0] MemAluRes,
  input  logic [DATA_W-1:0] WbData,
  output logic              StallF,
  output logic              BubbleE,
  output logic              FlushD,
  output logic              HoldM,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic [DATA_W-1:0] IdOpA,
  output logic [DATA_W-1:0] IdOpB,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCycles
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MWAIT} state_t;
  state_t state, state_nx;
  logic [TW-1:0] wait_cnt, wait_cnt_nx;
  logic ex_v, ex_rw, ex_mr, ex_mw, ex_urs, ex_urt;
  logic [REG_AW-1:0] ex_dst, ex_rs, ex_rt;
  logic mem_v, mem_rw, mem_mr, mem_mw;
  logic [REG_AW-1:0] mem_dst;
  logic wb_v, wb_rw;
  logic [REG_AW-1:0] wb_dst;
  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
  logic exa_mem, exa_wb, exb_mem, exb_wb;
  logic load_use, branch_dep, access, forced, release_now;

  function automatic logic hit(input logic v, input logic rw, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return v && rw && dst == src && src != '0;
  endfunction

  assign ex_rs_hit  = hit(ex_v, ex_rw, ex_dst, IdRs);
  assign ex_rt_hit  = hit(ex_v, ex_rw, ex_dst, IdRt);
  assign mem_rs_hit = hit(mem_v, mem_rw, mem_dst, IdRs);
  assign mem_rt_hit = hit(mem_v, mem_rw, mem_dst, IdRt);
  assign wb_rs_hit  = hit(wb_v, wb_rw, wb_dst, IdRs);
  assign wb_rt_hit  = hit(wb_v, wb_rw, wb_dst, IdRt);
  assign exa_mem = ex_v && ex_urs && hit(mem_v, mem_rw, mem_dst, ex_rs) && !mem_mr;
  assign exa_wb  = ex_v && ex_urs && hit(wb_v, wb_rw, wb_dst, ex_rs);
  assign exb_mem = ex_v && ex_urt && hit(mem_v, mem_rw, mem_dst, ex_rt) && !mem_mr;
  assign exb_wb  = ex_v && ex_urt && hit(wb_v, wb_rw, wb_dst, ex_rt);

  assign load_use   = ex_mr && (IdUsesRs && ex_rs_hit || IdUsesRt && ex_rt_hit);
  assign branch_dep = IdIsBranch && (IdUsesRs && (ex_rs_hit || mem_mr && mem_rs_hit) ||
                                     IdUsesRt && (ex_rt_hit || mem_mr && mem_rt_hit));

  assign FwdA  = exa_mem ? 2'd2 : exa_wb ? 2'd1 : 2'd0;
  assign FwdB  = exb_mem ? 2'd2 : exb_wb ? 2'd1 : 2'd0;
  assign IdOpA = mem_rs_hit && !mem_mr ? MemAluRes : wb_rs_hit ? WbData : RfRs;
  assign IdOpB = mem_rt_hit && !mem_mr ? MemAluRes : wb_rt_hit ? WbData : RfRt;

  assign access      = mem_v && (mem_mr || mem_mw);
  assign forced      = state == MWAIT && wait_cnt >= TW'(MEM_TIMEOUT - 1);
  assign release_now = MemReady || forced;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state       <= RUN;
      wait_cnt    <= '0;
      MemTimeout  <= 1'b0;
      StallCycles <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (access && !MemReady && forced) MemTimeout <= 1'b1;
      if (StallF && ~&StallCycles) StallCycles <= StallCycles + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state == RUN ? (HoldM ? MWAIT : RUN) : (release_now ? RUN : MWAIT);
    wait_cnt_nx = state == RUN ? (HoldM ? TW'(1) : '0) : (release_now ? '0 : wait_cnt + TW'(1));
  end

  // A frozen memory stage already stops the front end, so it masks stall and flush.
  always_comb begin
    HoldM   = access && !MemReady && !forced;
    StallF  = IdValid && !HoldM && (load_use || branch_dep);
    BubbleE = StallF;
    FlushD  = IdValid && IdIsBranch && BranchTaken && !StallF && !HoldM;
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      ex_v  <= 1'b0;
      mem_v <= 1'b0;
      wb_v  <= 1'b0;
    end else if (HoldM) begin
      wb_v <= 1'b0;
    end else begin
      wb_v    <= mem_v;
      wb_dst  <= mem_dst;
      wb_rw   <= mem_rw;
      mem_v   <= ex_v;
      mem_dst <= ex_dst;
      mem_rw  <= ex_rw;
      mem_mr  <= ex_mr;
      mem_mw  <= ex_mw;
      ex_v    <= IdValid && !BubbleE;
      ex_dst  <= IdDst;
      ex_rw   <= IdRegWrite;
      ex_mr   <= IdMemRead;
      ex_mw   <= IdMemWrite;
      ex_rs   <= IdRs;
      ex_rt   <= IdRt;
      ex_urs  <= IdUsesRs;
      ex_urt  <= IdUsesRt;
    end
  end
endmodule
